// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encoding, frame index constants and even-parity helper
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int START_IDX = 0;
  localparam int FIRST_DATA_IDX = 1;
  function automatic int last_data_idx(input int dw);
    return dw;
  endfunction
  function automatic int parity_idx(input int dw);
    return dw + 1;
  endfunction
  function automatic int stop_idx(input int dw);
    return dw + 2;
  endfunction
  function automatic int frame_bits(input int dw);
    return dw + 3;
  endfunction
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for the asynchronous serial line, resets to idle-high
// Ports: clk, rst_n (async active-low), i_d (async line in), o_q (synchronised line)
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_sync;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_sync <= 2'b11;
    else r_sync <= {r_sync[0], i_d};
  assign o_q = r_sync[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: UART receive stage (start, MSB-first data, even parity, stop) into a valid/ready holding register
// Ports: clk, rst_n (async active-low), rx_enable, rx_in (async serial line),
//   rx_data_out/rx_valid/rx_ready (holding-register handshake), parity_err/frame_err (qualified by rx_valid),
//   overrun (sticky until a handshake), busy (FSM outside IDLE)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_enable,
  input  logic                  rx_in,
  output logic [DATA_WIDTH-1:0] rx_data_out,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF > 0 ? HALF - 1 : 0);
  localparam logic [BW-1:0] FIRST_DATA = BW'(FIRST_DATA_IDX);
  localparam logic [BW-1:0] LAST_DATA = BW'(last_data_idx(DATA_WIDTH));
  uart_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic r_perr, w_perr_nxt, r_armed, w_armed_nxt;
  logic w_rx_s, w_tick, w_done, w_hs, w_load;
  uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .i_d(rx_in), .o_q(w_rx_s));
  assign w_tick = r_cnt == '0;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = w_tick ? BIT_LAST : r_cnt - CW'(1);
    w_bit_nxt = r_bit;
    w_shift_nxt = r_shift;
    w_perr_nxt = r_perr;
    w_armed_nxt = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_armed_nxt = r_armed | w_rx_s;
        w_bit_nxt = FIRST_DATA;
        // with one clock per bit the detection sample is already the start sample
        w_cnt_nxt = HALF == 0 ? BIT_LAST : HALF_LAST;
        if (r_armed && !w_rx_s) begin
          w_state_nxt = HALF == 0 ? DATA : START;
          w_armed_nxt = 1'b0;
        end
      end
      START: if (w_tick) w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA: if (w_tick) begin
        w_shift_nxt = DATA_WIDTH'({r_shift, w_rx_s});
        w_bit_nxt = r_bit + BW'(1);
        w_state_nxt = r_bit == LAST_DATA ? PARITY : DATA;
      end
      PARITY: if (w_tick) begin
        w_perr_nxt = w_rx_s ^ even_parity(64'(r_shift));
        w_state_nxt = STOP;
      end
      STOP: if (w_tick) begin
        w_done = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (!rx_enable) begin
      w_state_nxt = IDLE;
      w_armed_nxt = 1'b0;
      w_done = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_perr <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      r_bit <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_perr <= w_perr_nxt;
      r_armed <= w_armed_nxt;
    end
  assign w_hs = rx_valid & rx_ready;
  // a finished frame may refill the register on the same edge it is being drained
  assign w_load = w_done & (!rx_valid | w_hs);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_data_out <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (w_load) begin
        rx_data_out <= r_shift;
        parity_err <= r_perr;
        frame_err <= !w_rx_s;
      end
      rx_valid <= w_load | (rx_valid & !rx_ready);
      overrun <= (w_done & !w_load) | (overrun & !w_hs);
    end
  assign busy = r_state != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed plus randomized frames against a holding-register reference model
module tb_uart_receiver;
  logic clk = 1'b0, rst_n = 1'b0, rx_enable = 1'b1;
  logic rx1 = 1'b1, rx16 = 1'b1, rdy1 = 1'b0, rdy16 = 1'b0;
  logic [7:0] d1, d16;
  logic v1, v16, pe1, pe16, fe1, fe16, ov1, ov16, b1, b16;
  int n_pass = 0, n_fail = 0;
  logic m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = 8'h00;
  always #5 clk = ~clk;
  uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .rx_in(rx1), .rx_data_out(d1),
    .rx_valid(v1), .rx_ready(rdy1), .parity_err(pe1), .frame_err(fe1), .overrun(ov1), .busy(b1));
  uart_receiver #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) u16 (
    .clk(clk), .rst_n(rst_n), .rx_enable(rx_enable), .rx_in(rx16), .rx_data_out(d16),
    .rx_valid(v16), .rx_ready(rdy16), .parity_err(pe16), .frame_err(fe16), .overrun(ov16), .busy(b16));
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic put(input bit sel, input logic b, input int n);
    if (sel) rx16 = b;
    else rx1 = b;
    tick(n);
  endtask
  task automatic send(input bit sel, input logic [7:0] d, input logic p, input logic s);
    int c = sel ? 16 : 1;
    put(sel, 1'b0, c);
    for (int i = 7; i >= 0; i--) put(sel, d[i], c);
    put(sel, p, c);
    put(sel, s, c);
  endtask
  task automatic deliver(input logic [7:0] d, input logic p, input logic s);
    if (m_valid) m_ovr = 1'b1;
    else begin
      m_valid = 1'b1;
      m_data = d;
      m_perr = p ^ (^d);
      m_ferr = !s;
    end
  endtask
  task automatic accept();
    rdy1 = 1'b1;
    tick();
    rdy1 = 1'b0;
    if (m_valid) begin
      m_valid = 1'b0;
      m_ovr = 1'b0;
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".valid"}, v1, m_valid);
    chk({tag, ".data"}, d1, m_data);
    if (m_valid) begin
      chk({tag, ".perr"}, pe1, m_perr);
      chk({tag, ".ferr"}, fe1, m_ferr);
    end
    chk({tag, ".ovr"}, ov1, m_ovr);
    chk({tag, ".busy"}, b1, 1'b0);
  endtask
  task automatic frame1(input string tag, input logic [7:0] d, input logic p, input logic s);
    send(0, d, p, s);
    put(0, 1'b1, 4);
    deliver(d, p, s);
    check_all(tag);
    accept();
    check_all({tag, ".acc"});
  endtask
  initial begin
    logic [7:0] d;
    logic bp, bs;
    tick(3);
    check_all("reset");
    chk("reset.v16", v16, 0);
    chk("reset.b16", b16, 0);
    chk("reset.ov16", ov16, 0);
    rst_n = 1'b1;
    tick(3);
    rdy1 = 1'b1;
    send(0, 8'hA5, 1'b0, 1'b1);
    chk("a5.busy", b1, 1);
    chk("a5.early", v1, 0);
    tick();
    chk("a5.pre", v1, 0);
    tick();
    chk("a5.valid", v1, 1);
    chk("a5.data", d1, 8'hA5);
    chk("a5.perr", pe1, 0);
    chk("a5.ferr", fe1, 0);
    chk("a5.ovr", ov1, 0);
    tick();
    chk("a5.pulse", v1, 0);
    chk("a5.idle", b1, 0);
    rdy1 = 1'b0;
    m_data = 8'hA5;
    tick(2);
    frame1("par", 8'h3C, 1'b1, 1'b1);
    send(0, 8'h81, 1'b0, 1'b0);
    put(0, 1'b0, 5);
    chk("ferr.noarm", b1, 0);
    put(0, 1'b1, 4);
    deliver(8'h81, 1'b0, 1'b0);
    check_all("ferr");
    accept();
    frame1("after_ferr", 8'h55, 1'b0, 1'b1);
    send(0, 8'h11, 1'b0, 1'b1);
    put(0, 1'b1, 4);
    deliver(8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    put(0, 1'b1, 4);
    deliver(8'h22, 1'b0, 1'b1);
    check_all("ovr");
    accept();
    check_all("ovr.acc");
    frame1("after_ovr", 8'h33, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom);
      bp = ($urandom % 4) == 0;
      bs = ($urandom % 4) == 0;
      send(0, d, (^d) ^ bp, !bs);
      if (bs) put(0, 1'b0, $urandom_range(1, 4));
      put(0, 1'b1, 4 + $urandom_range(0, 3));
      deliver(d, (^d) ^ bp, !bs);
      check_all("rand");
      accept();
      check_all("rand.acc");
    end
    put(1, 1'b0, 3);
    chk("glitch.busy", b16, 1);
    put(1, 1'b1, 20);
    chk("glitch.idle", b16, 0);
    chk("glitch.valid", v16, 0);
    send(1, 8'hC3, 1'b0, 1'b1);
    put(1, 1'b1, 2);
    chk("c3.valid", v16, 1);
    chk("c3.data", d16, 8'hC3);
    chk("c3.perr", pe16, 0);
    chk("c3.ferr", fe16, 0);
    chk("c3.busy", b16, 0);
    rdy16 = 1'b1;
    tick();
    rdy16 = 1'b0;
    chk("c3.acc", v16, 0);
    d = 8'($urandom);
    send(1, d, !(^d), 1'b1);
    put(1, 1'b1, 2);
    chk("r16.valid", v16, 1);
    chk("r16.data", d16, d);
    chk("r16.perr", pe16, 1);
    chk("r16.ovr", ov16, 0);
    send(0, 8'h66, 1'b0, 1'b1);
    put(0, 1'b1, 4);
    deliver(8'h66, 1'b0, 1'b1);
    d = 8'($urandom);
    put(0, 1'b0, 1);
    for (int i = 7; i >= 4; i--) put(0, d[i], 1);
    chk("rst.busy", b1, 1);
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    m_data = 8'h00;
    m_perr = 1'b0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    check_all("rst.async");
    chk("rst.v16", v16, 0);
    rx1 = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(3);
    check_all("rst.after");
    frame1("rst.next", 8'h9E, 1'b0, 1'b1);
    send(0, 8'h4B, 1'b0, 1'b1);
    put(0, 1'b1, 4);
    deliver(8'h4B, 1'b0, 1'b1);
    d = 8'($urandom);
    put(0, 1'b0, 1);
    for (int i = 7; i >= 4; i--) put(0, d[i], 1);
    chk("en.busy", b1, 1);
    rx_enable = 1'b0;
    rx1 = 1'b1;
    tick();
    rx_enable = 1'b1;
    tick(5);
    check_all("en.held");
    accept();
    frame1("en.next", 8'hE7, 1'b0, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
